// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game core: FSM states, LFSR
// geometry and the symbol-to-colour mapping.
package genius_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY,
    ST_PLAY
  } state_t;

  localparam int          LFSR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  localparam logic [1:0] COLOUR_GREEN = 2'd0;
  localparam logic [1:0] COLOUR_RED   = 2'd1;
  localparam logic [1:0] COLOUR_BLUE  = 2'd2;

endpackage

// File: rtl/genius_lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load and advance enable.
// Only the low RAW_W bits are exported; they feed the symbol mapper.
module genius_lfsr16
  import genius_pkg::*;
#(
  parameter logic [15:0] SEED_RESET = SEED_DEFAULT,
  parameter int          RAW_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [15:0]       i_load_val,
  input  logic              i_advance,
  output logic [RAW_W-1:0]  o_raw
);

  logic [LFSR_W-1:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED_RESET;
    end else if (i_load) begin
      // An all-zero seed would lock the LFSR; substitute 1.
      r_lfsr <= (i_load_val == '0) ? 16'h0001 : i_load_val;
    end else if (i_advance) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign o_raw = r_lfsr[RAW_W-1:0];

endmodule

// File: rtl/genius_sequence_gen.sv
// Sequence memory for the Genius game: filled from the LFSR on start, read
// randomly by index, and streamed over a valid/ready playback port.
module genius_sequence_gen
  import genius_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          SYM_W       = 2,
  parameter int          NUM_SYMBOLS = 3,
  parameter logic [15:0] SEED_RESET  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_seed_load,
  input  logic [15:0]                  i_seed_in,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(DEPTH)-1:0]     i_rd_idx,
  output logic [SYM_W-1:0]             o_rd_sym,
  input  logic                         i_play_start,
  input  logic [$clog2(DEPTH+1)-1:0]   i_play_len,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [SYM_W-1:0]             o_out_sym,
  output logic [$clog2(DEPTH)-1:0]     o_out_idx,
  output logic                         o_out_last
);

  localparam int                 IDX_W    = $clog2(DEPTH);
  localparam int                 LEN_W    = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(DEPTH);
  localparam logic [SYM_W:0]     NSYM     = (SYM_W + 1)'(NUM_SYMBOLS);

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_wi, r_pi;
  logic [LEN_W-1:0]   r_len;
  logic [SYM_W-1:0]   r_mem [DEPTH];
  logic               r_done;

  logic [SYM_W-1:0]   w_raw, w_sym;
  logic [SYM_W:0]     w_raw_ext;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_idle_rdy, w_start_ok, w_play_ok, w_fill_last, w_play_last;

  genius_lfsr16 #(.SEED_RESET(SEED_RESET), .RAW_W(SYM_W)) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (i_seed_load & w_idle_rdy),
    .i_load_val (i_seed_in),
    .i_advance  (r_state == ST_FILL),
    .o_raw      (w_raw)
  );

  // Fold out-of-range raw values back into 0..NUM_SYMBOLS-1.
  assign w_raw_ext     = {1'b0, w_raw};
  assign w_sym         = (w_raw_ext >= NSYM) ? SYM_W'(w_raw_ext - NSYM) : w_raw;

  assign w_idle_rdy    = (r_state == ST_IDLE) || (r_state == ST_READY);
  assign w_start_ok    = w_idle_rdy && i_start;
  assign w_play_ok     = (r_state == ST_READY) && i_play_start && !i_start && (i_play_len != '0);
  assign w_len_clamped = (i_play_len > LEN_MAX) ? LEN_MAX : i_play_len;
  assign w_fill_last   = (r_state == ST_FILL) && (r_wi == IDX_LAST);
  assign w_play_last   = (LEN_W'(r_pi) == r_len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_FILL;
      ST_FILL: begin
        o_busy = 1'b1;
        if (w_fill_last) w_next = ST_READY;
      end
      ST_READY: begin
        if (w_start_ok)     w_next = ST_FILL;
        else if (w_play_ok) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        o_out_valid = 1'b1;
        if (i_out_ready && w_play_last) w_next = ST_READY;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: the sequence memory is deliberately reset; the game relies on a
  // cleared memory after reset, so it stays in flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_FILL) begin
      r_mem[r_wi] <= w_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wi   <= '0;
      r_pi   <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fill_last;
      if (w_start_ok)               r_wi <= '0;
      else if (r_state == ST_FILL)  r_wi <= r_wi + IDX_W'(1);
      if (w_play_ok) begin
        r_pi  <= '0;
        r_len <= w_len_clamped;
      end else if (r_state == ST_PLAY && i_out_ready) begin
        r_pi  <= r_pi + IDX_W'(1);
      end
    end
  end

  assign o_done     = r_done;
  assign o_rd_sym   = r_mem[i_rd_idx];
  assign o_out_sym  = o_out_valid ? r_mem[r_pi] : '0;
  assign o_out_idx  = o_out_valid ? r_pi : '0;
  assign o_out_last = o_out_valid && w_play_last;

endmodule

// File: tb/tb_genius_sequence_gen.sv
// Self-checking bench for genius_sequence_gen: directed corner cases plus
// randomized seeds/playback against a behavioural sequence model.
module tb_genius_sequence_gen;

  localparam int DEPTH = 16;
  localparam int SYM_W = 2;
  localparam int NSYM  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_seed_load, i_start, i_play_start, i_out_ready;
  logic [15:0] i_seed_in;
  logic [3:0]  i_rd_idx;
  logic [4:0]  i_play_len;
  logic        o_busy, o_done, o_out_valid, o_out_last;
  logic [1:0]  o_rd_sym, o_out_sym;
  logic [3:0]  o_out_idx;
  logic        b_busy, b_done, b_out_valid, b_out_last;
  logic [1:0]  b_rd_sym, b_out_sym;
  logic [3:0]  b_out_idx;

  always #5 clk = ~clk;

  genius_sequence_gen #(.DEPTH(DEPTH), .SYM_W(SYM_W), .NUM_SYMBOLS(NSYM)) dut (
    .clk(clk), .reset(reset), .i_seed_load(i_seed_load), .i_seed_in(i_seed_in),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .i_rd_idx(i_rd_idx),
    .o_rd_sym(o_rd_sym), .i_play_start(i_play_start), .i_play_len(i_play_len),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_sym(o_out_sym),
    .o_out_idx(o_out_idx), .o_out_last(o_out_last)
  );

  // Four-symbol variant: symbols must equal the raw LFSR low bits.
  genius_sequence_gen #(.DEPTH(DEPTH), .SYM_W(SYM_W), .NUM_SYMBOLS(4)) dut4 (
    .clk(clk), .reset(reset), .i_seed_load(i_seed_load), .i_seed_in(i_seed_in),
    .i_start(i_start), .o_busy(b_busy), .o_done(b_done), .i_rd_idx(i_rd_idx),
    .o_rd_sym(b_rd_sym), .i_play_start(i_play_start), .i_play_len(i_play_len),
    .o_out_valid(b_out_valid), .i_out_ready(i_out_ready), .o_out_sym(b_out_sym),
    .o_out_idx(b_out_idx), .o_out_last(b_out_last)
  );

  int n_vec = 0;
  int n_err = 0;

  int m_lfsr;
  int m_mem [DEPTH];
  int m_raw [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int l);
    return (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
  endfunction

  function automatic int sym_of(input int l);
    int r;
    r = l % (1 << SYM_W);
    return (r >= NSYM) ? r - NSYM : r;
  endfunction

  function automatic void model_reset();
    m_lfsr = 'hACE1;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_raw[i] = 0;
    end
  endfunction

  function automatic void model_fill();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = sym_of(m_lfsr);
      m_raw[i] = m_lfsr % 4;
      m_lfsr   = lfsr_next(m_lfsr);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      i_rd_idx = 4'(i);
      #1;
      check({tag, "_sym"}, 32'(o_rd_sym), 32'(m_mem[i]));
      check({tag, "_lt3"}, 32'(o_rd_sym < 2'd3), 32'd1);
      check({tag, "_raw4"}, 32'(b_rd_sym), 32'(m_raw[i]));
    end
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_valid"}, 32'(o_out_valid), 0);
    check({tag, "_osym"},  32'(o_out_sym), 0);
    check({tag, "_oidx"},  32'(o_out_idx), 0);
    check({tag, "_olast"}, 32'(o_out_last), 0);
    sweep({tag, "_mem"});
  endtask

  // Start already sampled; counts busy cycles and returns in the done cycle.
  task automatic run_fill(input string tag);
    int  bc;
    bit  seen;
    bc = 0;
    seen = 0;
    model_fill();
    for (int c = 0; c < DEPTH + 8; c++) begin
      if (o_busy) bc++;
      if (o_done) begin
        seen = 1;
        check({tag, "_busy_at_done"}, 32'(o_busy), 0);
        break;
      end
      step();
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'(DEPTH));
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  task automatic start_fill(input string tag);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    run_fill(tag);
  endtask

  task automatic check_first5(input string tag);
    int exp5 [5] = '{1, 0, 0, 0, 2};
    for (int i = 0; i < 5; i++) begin
      i_rd_idx = 4'(i);
      #1;
      check({tag, "_first5"}, 32'(o_rd_sym), 32'(exp5[i]));
    end
  endtask

  // mode 0: ready held 1, 1: toggle 1,0,..., 2: random.
  task automatic play(input string tag, input int len, input int mode,
                      input bit inject, input int abort_at);
    int L, idx, cyc;
    bit rdy;
    L = (len == 0) ? 0 : ((len > DEPTH) ? DEPTH : len);
    i_play_len   = 5'(len);
    i_play_start = 1'b1;
    step();
    i_play_start = 1'b0;
    if (L == 0) begin
      check({tag, "_ignored_valid"}, 32'(o_out_valid), 0);
      step();
      check({tag, "_ignored_valid2"}, 32'(o_out_valid), 0);
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < L && cyc < 200) begin
      if (abort_at >= 0 && cyc == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_out_ready = 1'b0;
        model_reset();
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_out_ready = rdy;
      if (inject) begin
        i_start      = (cyc == 2);
        i_play_start = (cyc == 2);
      end
      check({tag, "_valid"}, 32'(o_out_valid), 1);
      check({tag, "_idx"},   32'(o_out_idx), 32'(idx));
      check({tag, "_sym"},   32'(o_out_sym), 32'(m_mem[idx]));
      check({tag, "_last"},  32'(o_out_last), 32'(idx == L - 1));
      check({tag, "_busy"},  32'(o_busy), 0);
      if (rdy) idx++;
      cyc++;
      step();
    end
    i_start      = 1'b0;
    i_play_start = 1'b0;
    i_out_ready  = 1'b0;
    check({tag, "_beats"}, 32'(idx), 32'(L));
    check({tag, "_end_valid"}, 32'(o_out_valid), 0);
    if (mode == 0) check({tag, "_cycles"}, 32'(cyc), 32'(L));
  endtask

  initial begin
    int seed;
    reset = 1'b1;
    i_seed_load = 0; i_seed_in = '0; i_start = 0; i_play_start = 0;
    i_out_ready = 0; i_rd_idx = '0; i_play_len = '0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    check_idle_outputs("rst");

    start_fill("fillA");
    check_first5("fillA");
    step();
    check("fillA_done_pulse", 32'(o_done), 0);
    sweep("fillA");

    start_fill("fillB");
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("b2b_accept", 32'(o_busy), 1);
    run_fill("fillC");
    sweep("fillC");

    i_seed_in = 16'h0000;
    i_seed_load = 1'b1;
    step();
    i_seed_load = 1'b0;
    m_lfsr = 1;
    start_fill("seed0");
    i_rd_idx = 4'd0;
    #1;
    check("seed0_mem0", 32'(o_rd_sym), 1);
    sweep("seed0");
    i_seed_load = 1'b1;
    i_start = 1'b1;
    step();
    i_seed_load = 1'b0;
    i_start = 1'b0;
    m_lfsr = 1;
    run_fill("seed0_again");
    sweep("seed0_again");

    play("p5", 5, 1, 0, -1);
    play("p0", 0, 0, 0, -1);
    play("p20", 20, 0, 0, -1);

    i_start = 1'b1;
    i_play_start = 1'b1;
    i_play_len = 5'd5;
    step();
    i_start = 1'b0;
    i_play_start = 1'b0;
    check("startwin_valid", 32'(o_out_valid), 0);
    check("startwin_busy", 32'(o_busy), 1);
    run_fill("startwin");
    sweep("startwin");

    play("inject", 10, 2, 1, -1);
    sweep("after_inject");

    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (6) step();
    check("midfill_busy", 32'(o_busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check_idle_outputs("rst_fill");
    start_fill("post_rst_fill");
    check_first5("post_rst_fill");
    sweep("post_rst_fill");

    play("midplay", 12, 0, 0, 4);
    check_idle_outputs("rst_play");
    start_fill("post_rst_play");
    check_first5("post_rst_play");

    for (int t = 0; t < 6; t++) begin
      seed = int'($urandom_range(0, 65535));
      if (t == 0) seed = 0;
      i_seed_in = 16'(seed);
      i_seed_load = 1'b1;
      i_start = 1'b1;
      step();
      i_seed_load = 1'b0;
      i_start = 1'b0;
      m_lfsr = (seed == 0) ? 1 : seed;
      run_fill("rnd_fill");
      sweep("rnd_fill");
      play("rnd_play", int'($urandom_range(0, 31)), 2, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
